// File: rtl/serial_shift_rx.sv
// -----------------------------------------------------------------------------
// serial_shift_rx
//
// Receive end of the board's serial shift-out link (serial clock, serial data,
// active-low clear, latch strobe). The link is oversampled with the system
// clock. MSB-first frames of WIDTH bits are deserialized. On the latch strobe
// a complete frame is presented as a parallel word with a valid/ack handshake.
//
// Build option:
//   SRX_GLITCH_FILTER_EN  when defined, a 3-tap majority filter follows the
//                         synchronizers on sclk and spen. Single-cycle glitches
//                         are rejected. Shift and latch latency grow from
//                         3 to 5 clk.
//
// Parameters:
//   WIDTH      frame length in bits, 2..64
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   sclk       serial shift clock, asynchronous to clk
//   sdat       serial data, MSB first, sampled on the sclk rising edge
//   sclrn      active-low frame clear
//   spen       latch strobe; its rising edge ends a frame
//   rx_data    last accepted frame
//   rx_valid   rx_data holds an unacknowledged frame
//   rx_ack     consumer acknowledge, single-cycle pulse
//   frame_err  sticky: a latch arrived with the wrong bit count
//   overrun    sticky: a frame was accepted while rx_valid was still high
//   err_clr    clears frame_err and overrun
//   bit_cnt    bits shifted since the last clear or latch (debug)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module serial_shift_rx #(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             sdat,
    input  logic             sclrn,
    input  logic             spen,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ack,
    output logic             frame_err,
    output logic             overrun,
    input  logic             err_clr,
    output logic [CNT_W-1:0] bit_cnt
);

    // Count value that marks a complete frame, and the saturation value that
    // marks a frame that ran long.
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

    // -------------------------------------------------------------------------
    // Input synchronizers
    // -------------------------------------------------------------------------
    logic [1:0] sclk_sync_q;
    logic [1:0] sdat_sync_q;
    logic [1:0] sclrn_sync_q;
    logic [1:0] spen_sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours; blocking here would
    // collapse the two synchronizer stages into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q  <= '0;
            sdat_sync_q  <= '0;
            // The clear synchronizer idles high so leaving reset is not
            // mistaken for a frame clear.
            sclrn_sync_q <= '1;
            spen_sync_q  <= '0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[0],  sclk};
            sdat_sync_q  <= {sdat_sync_q[0],  sdat};
            sclrn_sync_q <= {sclrn_sync_q[0], sclrn};
            spen_sync_q  <= {spen_sync_q[0],  spen};
        end
    end

    // -------------------------------------------------------------------------
    // Optional glitch filter. sdat is delayed by the same two cycles the
    // filter adds, so data is always sampled at the same point relative to
    // the sclk rise in both builds.
    // -------------------------------------------------------------------------
    logic sclk_cond;
    logic spen_cond;
    logic sdat_cond;

`ifdef SRX_GLITCH_FILTER_EN
    logic [1:0] sclk_hist_q;
    logic [1:0] spen_hist_q;
    logic [1:0] sdat_dly_q;
    logic       sclk_filt_q;
    logic       spen_filt_q;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_hist_q <= '0;
            spen_hist_q <= '0;
            sdat_dly_q  <= '0;
            sclk_filt_q <= 1'b0;
            spen_filt_q <= 1'b0;
        end else begin
            sclk_hist_q <= {sclk_hist_q[0], sclk_sync_q[1]};
            spen_hist_q <= {spen_hist_q[0], spen_sync_q[1]};
            sdat_dly_q  <= {sdat_dly_q[0],  sdat_sync_q[1]};
            // A one-cycle pulse only ever occupies one of the three taps,
            // so it never wins the vote.
            sclk_filt_q <= maj3(sclk_sync_q[1], sclk_hist_q[0], sclk_hist_q[1]);
            spen_filt_q <= maj3(spen_sync_q[1], spen_hist_q[0], spen_hist_q[1]);
        end
    end

    assign sclk_cond = sclk_filt_q;
    assign spen_cond = spen_filt_q;
    assign sdat_cond = sdat_dly_q[1];
`else
    assign sclk_cond = sclk_sync_q[1];
    assign spen_cond = spen_sync_q[1];
    assign sdat_cond = sdat_sync_q[1];
`endif

    logic sclrn_s;
    assign sclrn_s = sclrn_sync_q[1];

    // -------------------------------------------------------------------------
    // Edge detection. sclk and spen go through identical pipelines, so a
    // shift and a latch arriving one clk apart on the wire stay in order.
    // -------------------------------------------------------------------------
    logic sclk_prev_q;
    logic spen_prev_q;
    logic sclk_rise;
    logic spen_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_prev_q <= 1'b0;
            spen_prev_q <= 1'b0;
        end else begin
            sclk_prev_q <= sclk_cond;
            spen_prev_q <= spen_cond;
        end
    end

    assign sclk_rise = sclk_cond & ~sclk_prev_q;
    assign spen_rise = spen_cond & ~spen_prev_q;

    // -------------------------------------------------------------------------
    // Frame datapath
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] shreg_q,     shreg_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] rx_data_q,   rx_data_d;
    logic             rx_valid_q,  rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q,   overrun_d;

    // NOTE: every signal driven here gets a default on entry, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        // Shift stage. Clear wins over a shift in the same cycle.
        if (!sclrn_s) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (sclk_rise) begin
            shreg_d = {shreg_q[WIDTH-2:0], sdat_cond};
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Clear first so an error event in the same cycle sets the flag.
        if (err_clr) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end

        if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
        end

        // Latch stage sees the post-shift count and register, so a shift
        // that lands in the same cycle as the latch is included.
        if (spen_rise) begin
            if (cnt_d == CNT_FULL) begin
                rx_data_d  = shreg_d;
                rx_valid_d = 1'b1;
                // An ack in this same cycle consumes the old word, so the
                // replacement is not an overrun.
                if (rx_valid_q && !rx_ack) begin
                    overrun_d = 1'b1;
                end
            end else begin
                frame_err_d = 1'b1;
            end
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q     <= '0;
            cnt_q       <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign bit_cnt   = cnt_q;

endmodule
